// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions: state encoding for the bit-serial subtractor FSM.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

  // Counter width for a WIDTH-cycle run, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/my_fsubtractor.sv
// One-bit full subtractor: D = A - B - Bi, with borrow-out Bo.
module my_fsubtractor (
  input  logic A,
  input  logic B,
  input  logic Bi,
  output logic D,
  output logic Bo
);

  assign D  = A ^ B ^ Bi;
  assign Bo = (~A & B) | (~(A ^ B) & Bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, behind a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sub_state_e       state_q;
  logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_q;
  logic             br_q, busy_q, done_q, bout_q;
  logic             bit_d, bit_bo;

  my_fsubtractor u_cell (
    .A  (sa_q[0]),
    .B  (sb_q[0]),
    .Bi (br_q),
    .D  (bit_d),
    .Bo (bit_bo)
  );

  // The completed result is res_d on the final RUN edge, so diff never shows partial bits.
  assign res_d = {bit_d, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          res_q <= res_d;
          br_q  <= bit_bo;
          if (cnt_q == CNT_LAST) begin
            diff_q  <= res_d;
            bout_q  <= bit_bo;
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept start; DONE falls back to IDLE otherwise.
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `diff = a - b` LSB-first over WIDTH clock cycles. It uses a single one-bit full-subtractor cell and a registered borrow. It is the inverse-operation companion to the combinational full-adder cell in the arithmetic library. It sits behind a simple start/busy/done handshake so control FSMs can issue subtractions without wide combinational borrow chains.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset_p`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a new subtraction. Sampled only in IDLE or DONE.
- `a`  in  WIDTH: minuend, captured on the accepted `start`.
- `b`  in  WIDTH: subtrahend, captured on the accepted `start`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse when the result becomes valid.
- `diff`  out  WIDTH: result `(a - b) mod 2^WIDTH`. Held stable from `done` until the next accepted `start`.
- `bout`  out  1: final borrow, 1 iff unsigned `a < b`. Held with `diff`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start`, capture `a` and `b` into shift registers `sa` and `sb`.
  - Clear the borrow register `br` and the bit counter `cnt`.
  - Go to RUN.
- RUN, each cycle:
  - Bit cell inputs: `x = sa[0]`, `y = sb[0]`, `bi = br`.
  - Bit difference: `d = x ^ y ^ bi`.
  - Borrow out: `bo = (~x & y) | (~(x ^ y) & bi)`.
  - `br <= bo`.
  - `sa` and `sb` shift right by 1.
  - The result shift register shifts right with `d` inserted at bit WIDTH-1.
  - `cnt` increments.
- Leave RUN after the cycle where `cnt == WIDTH-1`. On that edge:
  - Load `diff` from the completed shift register.
  - Load `bout` from the final `bo`.
  - Go to DONE.
- DONE lasts exactly one cycle with `done = 1`.
  - `start` in DONE is accepted exactly as in IDLE and goes straight to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- `start` during RUN is ignored: no capture and no effect on the operation in progress.
- `cnt` width is `$clog2(WIDTH)`, with a minimum of 1 bit. No wrap-around is reachable, because RUN exits at WIDTH-1.
- The result shift register is internal. `diff` and `bout` update only on RUN→DONE and never show partial results.

## Timing
- Reset (asynchronous assert, synchronous to `clk` on release):
  - State returns to IDLE.
  - `busy = 0`, `done = 0`, `diff = 0`, `bout = 0`.
  - `sa`, `sb`, `br`, `cnt` and the result register are cleared.
- Reset mid-RUN aborts the operation. Nothing is retained.
- Latency: `start` accepted at edge 0, `busy` high for cycles 1..WIDTH, `done` high in cycle WIDTH+1. For WIDTH=8, `done` is high 9 cycles after the `start` edge.
- Throughput: one result every WIDTH+1 cycles with back-to-back `start`.
- `busy` and `done` are registered (decoded from the state register). `busy` and `done` are never high together.

## Structure
- The shared arithmetic package holds the state encoding constants: `ST_IDLE = 2'd0`, `ST_RUN = 2'd1`, `ST_DONE = 2'd2`.
- Sub-module `my_fsubtractor`: one-bit full subtractor.
  - Inputs `A`, `B`, `Bi`; outputs `D`, `Bo`.
  - Purely combinational; instantiated once.
- Top level contains the FSM, counter, operand and result shift registers, borrow flop and output registers.

## Test plan
All scenarios use WIDTH=8.
- `a=0x35`, `b=0x12`, pulse `start` → `busy` for 8 cycles, then `done` 1 cycle, `diff=0x23`, `bout=0`.
- `a=0x12`, `b=0x35` → `diff=0xDD`, `bout=1`. Also `a=0x00`, `b=0x01` → `diff=0xFF`, `bout=1` (full borrow ripple).
- `a=0xFF`, `b=0xFF` → `diff=0x00`, `bout=0`. Also `a=0x80`, `b=0x00` → `diff=0x80`, `bout=0`.
- Change `a`/`b` and pulse `start` at cycle 3 of RUN → ignored. The result matches the originally captured operands, and `done` still occurs at cycle 9.
- Assert `reset_p` mid-RUN (cycle 4), release, then run `0x10 - 0x01`:
  - During reset all outputs are 0.
  - The new operation yields `diff=0x0F`, `bout=0` with normal latency.
- Hold `start` high across DONE with new operands `0x07 - 0x09` → immediate re-entry to RUN. The second `done` comes 9 cycles after the first, with `diff=0xFE`, `bout=1`. The first result stays on `diff` until the second `done`.
